// File: rtl/motor602_seq_ctrl.sv
// Run-state sequencer for the three-phase motor datapath: align, open-loop ramp,
// run and stop sequencing plus the operator speed/power setpoints.
//
// state | meaning
// IDLE  | outputs off, waiting for start with no force-stop
// ALIGN | rotor held on step 0 for ALIGN_CYC clocks
// RAMP  | stepping, period slewing from START_PERIOD toward target
// RUN   | stepping at (or tracking) the target period
// STOP  | all-off dwell of GAP_CYC clocks before IDLE
module motor602_seq_ctrl #(
    parameter logic [23:0] ALIGN_CYC    = 24'd500_000,
    parameter logic [23:0] START_PERIOD = 24'd1_000_000,
    parameter logic [23:0] INIT_TARGET  = 24'd200_000,
    parameter logic [23:0] MIN_PERIOD   = 24'd50_000,
    parameter logic [23:0] MAX_PERIOD   = 24'd2_000_000,
    parameter logic [23:0] RAMP_STEP    = 24'd10_000,
    parameter logic [23:0] SPEED_STEP   = 24'd5_000,
    parameter logic [23:0] REPEAT_CYC   = 24'd500_000,
    parameter logic [7:0]  DUTY_INIT    = 8'd64,
    parameter logic [7:0]  DUTY_STEP    = 8'd4,
    parameter logic [7:0]  DUTY_MIN     = 8'd16,
    parameter logic [7:0]  DUTY_MAX     = 8'd240,
    parameter logic [23:0] GAP_CYC      = 24'd250_000
) (
    input  logic        clk50mhzI,
    input  logic        nRstI,
    input  logic        m3startI,
    input  logic        m3forceStopI,
    input  logic        m3invRotateI,
    input  logic        m3speedINCi,
    input  logic        m3speedDECi,
    input  logic        m3powerINCi,
    input  logic        m3powerDECi,
    output logic        runEnO,
    output logic        dirO,
    output logic [2:0]  stepIdxO,
    output logic        stepStrobeO,
    output logic [23:0] periodO,
    output logic [7:0]  dutyO,
    output logic [2:0]  stateO
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        STOP  = 3'd4
    } seqStateT;

    localparam logic [24:0] MIN25   = {1'b0, MIN_PERIOD};
    localparam logic [24:0] MAX25   = {1'b0, MAX_PERIOD};
    localparam logic [24:0] SPEED25 = {1'b0, SPEED_STEP};
    localparam logic [24:0] RAMP25  = {1'b0, RAMP_STEP};
    localparam logic [8:0]  DMIN9   = {1'b0, DUTY_MIN};
    localparam logic [8:0]  DMAX9   = {1'b0, DUTY_MAX};
    localparam logic [8:0]  DSTEP9  = {1'b0, DUTY_STEP};

    seqStateT    state;
    logic [6:0]  rawIn;
    logic [6:0]  syncA;
    logic [6:0]  syncB;
    logic [3:0]  btnPrev;
    logic [3:0]  btnRise;
    logic        startS;
    logic        forceS;
    logic        invS;
    logic        spIncS;
    logic        spDecS;
    logic        pwIncS;
    logic        pwDecS;

    logic [23:0] spRep;
    logic [23:0] pwRep;
    logic [23:0] spRepNext;
    logic [23:0] pwRepNext;
    logic [1:0]  spTick;
    logic [1:0]  pwTick;
    logic [24:0] tgt;
    logic [24:0] tgtNext;
    logic [7:0]  dutySp;
    logic [7:0]  dutyNext;

    logic [23:0] stepCnt;
    logic [23:0] dwellCnt;
    logic [24:0] period25;
    logic [24:0] slewed;
    logic        rampDone;
    logic        stepTc;
    logic        stopReq;
    logic [2:0]  idxNext;

    assign stateO = state;
    assign rawIn  = {m3startI, m3forceStopI, m3invRotateI,
                     m3speedINCi, m3speedDECi, m3powerINCi, m3powerDECi};
    assign {startS, forceS, invS, spIncS, spDecS, pwIncS, pwDecS} = syncB;
    assign btnRise = syncB[3:0] & ~btnPrev;

    always_ff @(posedge clk50mhzI or negedge nRstI) begin
        if (!nRstI) begin
            syncA   <= '0;
            syncB   <= '0;
            btnPrev <= '0;
        end else begin
            syncA   <= rawIn;
            syncB   <= syncA;
            btnPrev <= syncB[3:0];
        end
    end

    // {incTick, decTick}: a fresh press ticks at once, a held press every REPEAT_CYC
    function automatic logic [1:0] tickOf(input logic inc, input logic dec,
                                          input logic incRise, input logic decRise,
                                          input logic repTc);
        logic [1:0] t;
        t = 2'b00;
        if (inc && !dec) begin
            t[1] = incRise || repTc;
        end else if (dec && !inc) begin
            t[0] = decRise || repTc;
        end
        return t;
    endfunction

    function automatic logic [23:0] repNext(input logic inc, input logic dec,
                                            input logic incRise, input logic decRise,
                                            input logic repTc, input logic [23:0] cnt);
        logic [23:0] n;
        n = '0;
        if (inc ^ dec) begin
            if (!((inc ? incRise : decRise) || repTc)) begin
                n = cnt + 24'd1;
            end
        end
        return n;
    endfunction

    assign spTick    = tickOf(spIncS, spDecS, btnRise[3], btnRise[2], spRep == REPEAT_CYC - 24'd1);
    assign pwTick    = tickOf(pwIncS, pwDecS, btnRise[1], btnRise[0], pwRep == REPEAT_CYC - 24'd1);
    assign spRepNext = repNext(spIncS, spDecS, btnRise[3], btnRise[2], spRep == REPEAT_CYC - 24'd1, spRep);
    assign pwRepNext = repNext(pwIncS, pwDecS, btnRise[1], btnRise[0], pwRep == REPEAT_CYC - 24'd1, pwRep);

    // Speed INC shortens the step period; clamps are arranged so no operand wraps
    always_comb begin
        tgtNext = tgt;
        if (spTick[1]) begin
            tgtNext = (tgt < MIN25 + SPEED25) ? MIN25 : tgt - SPEED25;
        end else if (spTick[0]) begin
            tgtNext = (tgt + SPEED25 > MAX25) ? MAX25 : tgt + SPEED25;
        end
    end

    always_comb begin
        dutyNext = dutySp;
        if (pwTick[1]) begin
            dutyNext = ({1'b0, dutySp} + DSTEP9 > DMAX9) ? DUTY_MAX : dutySp + DUTY_STEP;
        end else if (pwTick[0]) begin
            dutyNext = ({1'b0, dutySp} < DMIN9 + DSTEP9) ? DUTY_MIN : dutySp - DUTY_STEP;
        end
    end

    always_ff @(posedge clk50mhzI or negedge nRstI) begin
        if (!nRstI) begin
            tgt    <= {1'b0, INIT_TARGET};
            dutySp <= DUTY_INIT;
            spRep  <= '0;
            pwRep  <= '0;
        end else begin
            tgt    <= tgtNext;
            dutySp <= dutyNext;
            spRep  <= spRepNext;
            pwRep  <= pwRepNext;
        end
    end

    assign period25 = {1'b0, periodO};

    always_comb begin
        slewed = tgt;
        if (period25 > tgt) begin
            if (period25 > tgt + RAMP25) begin
                slewed = period25 - RAMP25;
            end
        end else if (period25 + RAMP25 < tgt) begin
            slewed = period25 + RAMP25;
        end
    end

    assign rampDone = (slewed == tgt);
    assign stepTc   = ({1'b0, stepCnt} + 25'd1 == period25);
    assign stopReq  = forceS || !startS || (invS != dirO);

    always_comb begin
        idxNext = stepIdxO;
        if (dirO) begin
            idxNext = (stepIdxO == 3'd0) ? 3'd5 : stepIdxO - 3'd1;
        end else begin
            idxNext = (stepIdxO == 3'd5) ? 3'd0 : stepIdxO + 3'd1;
        end
    end

    always_ff @(posedge clk50mhzI or negedge nRstI) begin
        if (!nRstI) begin
            state       <= IDLE;
            runEnO      <= 1'b0;
            dirO        <= 1'b0;
            stepIdxO    <= 3'd0;
            stepStrobeO <= 1'b0;
            periodO     <= START_PERIOD;
            dutyO       <= 8'd0;
            stepCnt     <= '0;
            dwellCnt    <= '0;
        end else begin
            stepStrobeO <= 1'b0;
            case (state)
                IDLE: begin
                    dutyO <= 8'd0;
                    if (startS && !forceS) begin
                        state    <= ALIGN;
                        dirO     <= invS;
                        runEnO   <= 1'b1;
                        stepIdxO <= 3'd0;
                        dutyO    <= dutyNext;
                        dwellCnt <= '0;
                    end
                end
                ALIGN: begin
                    if (stopReq) begin
                        state    <= STOP;
                        runEnO   <= 1'b0;
                        dutyO    <= 8'd0;
                        dwellCnt <= '0;
                    end else begin
                        dutyO <= dutyNext;
                        if (dwellCnt == ALIGN_CYC - 24'd1) begin
                            state    <= RAMP;
                            periodO  <= START_PERIOD;
                            stepCnt  <= '0;
                            dwellCnt <= '0;
                        end else begin
                            dwellCnt <= dwellCnt + 24'd1;
                        end
                    end
                end
                RAMP, RUN: begin
                    if (stopReq) begin
                        state    <= STOP;
                        runEnO   <= 1'b0;
                        dutyO    <= 8'd0;
                        dwellCnt <= '0;
                    end else begin
                        dutyO <= dutyNext;
                        if (stepTc) begin
                            stepStrobeO <= 1'b1;
                            stepCnt     <= '0;
                            stepIdxO    <= idxNext;
                            periodO     <= slewed[23:0];
                            if (state == RAMP && rampDone) begin
                                state <= RUN;
                            end
                        end else begin
                            stepCnt <= stepCnt + 24'd1;
                        end
                    end
                end
                STOP: begin
                    dutyO <= 8'd0;
                    if (dwellCnt == GAP_CYC - 24'd1) begin
                        state    <= IDLE;
                        dwellCnt <= '0;
                    end else begin
                        dwellCnt <= dwellCnt + 24'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    runEnO <= 1'b0;
                    dutyO  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor602_seq_ctrl.sv
// Bench for motor602_seq_ctrl: directed sequencing scenarios with literal
// expectations, then randomized operator activity against a behavioural model.
module tb_motor602_seq_ctrl;

    localparam int P_ALIGN  = 20;
    localparam int P_START  = 100;
    localparam int P_INIT   = 40;
    localparam int P_MIN    = 10;
    localparam int P_MAX    = 200;
    localparam int P_RAMP   = 20;
    localparam int P_SPEED  = 5;
    localparam int P_REPEAT = 50;
    localparam int P_GAP    = 30;
    localparam int D_INIT   = 64;
    localparam int D_STEP   = 4;
    localparam int D_MIN    = 16;
    localparam int D_MAX    = 240;

    localparam int S_IDLE  = 0;
    localparam int S_ALIGN = 1;
    localparam int S_RAMP  = 2;
    localparam int S_RUN   = 3;
    localparam int S_STOP  = 4;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic start = 1'b0, fstop = 1'b0, inv = 1'b0;
    logic spInc = 1'b0, spDec = 1'b0, pwInc = 1'b0, pwDec = 1'b0;

    logic        runEnO, dirO, stepStrobeO;
    logic [2:0]  stepIdxO, stateO;
    logic [23:0] periodO;
    logic [7:0]  dutyO;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    motor602_seq_ctrl #(
        .ALIGN_CYC(24'd20), .START_PERIOD(24'd100), .INIT_TARGET(24'd40),
        .MIN_PERIOD(24'd10), .MAX_PERIOD(24'd200), .RAMP_STEP(24'd20),
        .SPEED_STEP(24'd5), .REPEAT_CYC(24'd50),
        .DUTY_INIT(8'd64), .DUTY_STEP(8'd4), .DUTY_MIN(8'd16), .DUTY_MAX(8'd240),
        .GAP_CYC(24'd30)
    ) dut (
        .clk50mhzI(clk), .nRstI(nRst),
        .m3startI(start), .m3forceStopI(fstop), .m3invRotateI(inv),
        .m3speedINCi(spInc), .m3speedDECi(spDec),
        .m3powerINCi(pwInc), .m3powerDECi(pwDec),
        .runEnO(runEnO), .dirO(dirO), .stepIdxO(stepIdxO), .stepStrobeO(stepStrobeO),
        .periodO(periodO), .dutyO(dutyO), .stateO(stateO)
    );

    always #10 clk = ~clk;

    // Behavioural model: pin values seen two edges late, timers as "cycles left"
    int mState, mRunEn, mDir, mIdx, mStrobe, mPeriod, mDuty;
    int mTgt, mDutySp, mElapsed, mLeft, spCnt, pwCnt;
    bit [6:0] inHist[$];

    function automatic bit [6:0] pins();
        return {start, fstop, inv, spInc, spDec, pwInc, pwDec};
    endfunction

    task automatic modelReset();
        mState = S_IDLE; mRunEn = 0; mDir = 0; mIdx = 0; mStrobe = 0;
        mPeriod = P_START; mDuty = 0; mTgt = P_INIT; mDutySp = D_INIT;
        mElapsed = 0; mLeft = 0; spCnt = 0; pwCnt = 0;
        inHist = '{7'd0, 7'd0, 7'd0};
    endtask

    task automatic btn(input bit inc, input bit dec, input bit incP, input bit decP,
                       input int cntIn, output int cntOut, output int act);
        bit fresh;
        act = 0;
        cntOut = 0;
        if (inc != dec) begin
            fresh = inc ? !incP : !decP;
            if (fresh) begin
                act = inc ? 1 : -1;
            end else begin
                cntOut = cntIn + 1;
                if (cntOut == P_REPEAT) begin
                    act = inc ? 1 : -1;
                    cntOut = 0;
                end
            end
        end
    endtask

    task automatic modelStep();
        bit [6:0] c, p;
        int a, oldTgt;
        bit stopCond;
        c = inHist[1];
        p = inHist[2];
        btn(c[3], c[2], p[3], p[2], spCnt, spCnt, a);
        oldTgt = mTgt;
        if (a > 0) mTgt = (mTgt - P_SPEED < P_MIN) ? P_MIN : mTgt - P_SPEED;
        else if (a < 0) mTgt = (mTgt + P_SPEED > P_MAX) ? P_MAX : mTgt + P_SPEED;
        btn(c[1], c[0], p[1], p[0], pwCnt, pwCnt, a);
        if (a > 0) mDutySp = (mDutySp + D_STEP > D_MAX) ? D_MAX : mDutySp + D_STEP;
        else if (a < 0) mDutySp = (mDutySp - D_STEP < D_MIN) ? D_MIN : mDutySp - D_STEP;
        stopCond = c[5] || !c[6] || (int'(c[4]) != mDir);
        mStrobe = 0;
        case (mState)
            S_IDLE: if (c[6] && !c[5]) begin
                mDir = int'(c[4]); mIdx = 0; mLeft = P_ALIGN; mState = S_ALIGN;
            end
            S_ALIGN: if (stopCond) begin
                mState = S_STOP; mLeft = P_GAP;
            end else begin
                mLeft = mLeft - 1;
                if (mLeft == 0) begin
                    mState = S_RAMP; mPeriod = P_START; mElapsed = 0;
                end
            end
            S_RAMP, S_RUN: if (stopCond) begin
                mState = S_STOP; mLeft = P_GAP;
            end else begin
                mElapsed = mElapsed + 1;
                if (mElapsed == mPeriod) begin
                    mStrobe = 1;
                    mElapsed = 0;
                    mIdx = (mDir != 0) ? (mIdx + 5) % 6 : (mIdx + 1) % 6;
                    if (mPeriod > oldTgt)
                        mPeriod = (mPeriod - P_RAMP < oldTgt) ? oldTgt : mPeriod - P_RAMP;
                    else
                        mPeriod = (mPeriod + P_RAMP > oldTgt) ? oldTgt : mPeriod + P_RAMP;
                    if (mState == S_RAMP && mPeriod == oldTgt) mState = S_RUN;
                end
            end
            default: begin
                mLeft = mLeft - 1;
                if (mLeft == 0) mState = S_IDLE;
            end
        endcase
        mRunEn = (mState == S_ALIGN || mState == S_RAMP || mState == S_RUN) ? 1 : 0;
        mDuty = (mRunEn != 0) ? mDutySp : 0;
        inHist.push_front(pins());
        void'(inHist.pop_back());
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge nRst);
            if (!nRst) modelReset();
            else modelStep();
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Cycle-by-cycle compare of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmpEn) begin
                checks++;
                if (int'(runEnO) != mRunEn || int'(dirO) != mDir || int'(stepIdxO) != mIdx ||
                    int'(stepStrobeO) != mStrobe || int'(periodO) != mPeriod ||
                    int'(dutyO) != mDuty || int'(stateO) != mState) begin
                    failures++;
                    $display("FAIL outputs t=%0t: actual run=%0d dir=%0d idx=%0d stb=%0d per=%0d duty=%0d st=%0d required run=%0d dir=%0d idx=%0d stb=%0d per=%0d duty=%0d st=%0d",
                             $time, runEnO, dirO, stepIdxO, stepStrobeO, periodO, dutyO, stateO,
                             mRunEn, mDir, mIdx, mStrobe, mPeriod, mDuty, mState);
                end
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitStrobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!stepStrobeO && n < 1000);
    endtask

    task automatic waitState(input int st, input int budget, input string name);
        int n;
        n = 0;
        while (int'(stateO) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, stateO, st);
    endtask

    function automatic longint packedOut();
        return longint'({runEnO, dirO, stepIdxO, stepStrobeO, periodO, dutyO, stateO});
    endfunction

    localparam longint RESET_VEC = longint'({1'b0, 1'b0, 3'd0, 1'b0, 24'd100, 8'd0, 3'd0});

    initial begin
        int n, bad;
        int spacing1[6];
        spacing1 = '{100, 80, 60, 40, 40, 40};

        cyc(3);
        nRst = 1'b1;
        cmpEn = 1'b1;
        cyc(2);
        check("reset_outputs", packedOut(), RESET_VEC);
        check("reset_target", mTgt, 40);
        check("reset_duty_sp", mDutySp, 64);

        // start to RUN
        start = 1'b1;
        cyc(2);
        check("align_not_yet", stateO, S_IDLE);
        cyc(1);
        check("align_entry", stateO, S_ALIGN);
        check("align_runen", runEnO, 1);
        check("align_duty", dutyO, 64);
        cyc(19);
        check("align_hold", stateO, S_ALIGN);
        cyc(1);
        check("ramp_entry", stateO, S_RAMP);
        for (int i = 0; i < 6; i++) begin
            waitStrobe(n);
            check($sformatf("spacing%0d", i), n, spacing1[i]);
            check($sformatf("idx%0d", i), stepIdxO, (i + 1) % 6);
            if (i == 1) check("still_ramp", stateO, S_RAMP);
            if (i == 2) begin
                check("run_on_target", stateO, S_RUN);
                check("period_target", periodO, 40);
            end
        end

        // speed INC held 120 clocks, then held to saturation
        spInc = 1'b1;
        cyc(3);   check("tgt_tick0", mTgt, 35);
        cyc(50);  check("tgt_tick1", mTgt, 30);
        cyc(50);  check("tgt_tick2", mTgt, 25);
        cyc(17);
        spInc = 1'b0;
        cyc(5);   check("tgt_after_release", mTgt, 25);
        repeat (3) waitStrobe(n);
        check("period_follows_25", periodO, 25);
        spInc = 1'b1;
        cyc(103); check("tgt_floor", mTgt, 10);
        cyc(200); check("tgt_floor_hold", mTgt, 10);
        spInc = 1'b0;
        repeat (3) waitStrobe(n);
        check("period_follows_10", periodO, 10);

        // power INC held, saturation, both-high freeze
        check("duty_before", dutyO, 64);
        pwInc = 1'b1;
        cyc(3);   check("duty_tick0", dutyO, 68);
        cyc(50);  check("duty_tick1", dutyO, 72);
        cyc(50);  check("duty_tick2", dutyO, 76);
        cyc(50 * 45);
        check("duty_ceiling", dutyO, 240);
        pwDec = 1'b1;
        cyc(120); check("duty_both_high", dutyO, 240);
        pwInc = 1'b0;
        cyc(51);  check("duty_dec_wait", dutyO, 240);
        cyc(1);   check("duty_dec_tick", dutyO, 236);
        pwDec = 1'b0;
        cyc(5);

        // force-stop in RUN
        fstop = 1'b1;
        cyc(2);   check("stop_not_yet", stateO, S_RUN);
        cyc(1);
        check("stop_state", stateO, S_STOP);
        check("stop_runen", runEnO, 0);
        check("stop_duty", dutyO, 0);
        cyc(29);  check("stop_gap_hold", stateO, S_STOP);
        cyc(1);   check("stop_to_idle", stateO, S_IDLE);
        cyc(50);  check("idle_while_fstop", stateO, S_IDLE);
        fstop = 1'b0;
        cyc(3);   check("restart_align", stateO, S_ALIGN);
        waitState(S_RUN, 3000, "rerun");

        // reverse in RUN
        inv = 1'b1;
        cyc(3);
        check("rev_stop", stateO, S_STOP);
        check("rev_stop_runen", runEnO, 0);
        bad = 0;
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            if (runEnO || stateO != 3'(S_STOP)) bad++;
        end
        check("gap_runen_low", bad, 0);
        cyc(1);   check("rev_idle", stateO, S_IDLE);
        cyc(1);
        check("rev_align", stateO, S_ALIGN);
        check("rev_dir", dirO, 1);
        check("rev_idx0", stepIdxO, 0);
        cyc(20);  check("rev_ramp", stateO, S_RAMP);
        waitStrobe(n); check("rev_idx1", stepIdxO, 5); check("rev_sp1", n, 100);
        waitStrobe(n); check("rev_idx2", stepIdxO, 4); check("rev_sp2", n, 80);
        waitStrobe(n); check("rev_idx3", stepIdxO, 3); check("rev_sp3", n, 60);
        check("pre_reset_ramp", stateO, S_RAMP);

        // asynchronous reset mid-RAMP
        #2 nRst = 1'b0;
        #1 check("async_reset", packedOut(), RESET_VEC);
        cyc(3);
        check("reset_held", packedOut(), RESET_VEC);
        nRst = 1'b1;
        cyc(2);

        // randomized operator activity
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 1499) == 0) start = ~start;
            if (!start && $urandom_range(0, 199) == 0) start = 1'b1;
            if (fstop) begin
                if ($urandom_range(0, 99) == 0) fstop = 1'b0;
            end else if ($urandom_range(0, 2999) == 0) begin
                fstop = 1'b1;
            end
            if ($urandom_range(0, 2499) == 0) inv = ~inv;
            if ($urandom_range(0, 149) == 0) spInc = ~spInc;
            if ($urandom_range(0, 149) == 0) spDec = ~spDec;
            if ($urandom_range(0, 149) == 0) pwInc = ~pwInc;
            if ($urandom_range(0, 149) == 0) pwDec = ~pwDec;
        end
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
